// File: rtl/obstacle_scheduler_pkg.sv
// Shared lane-game definitions: lane codes, screen geometry and scheduler state encoding.
package obstacle_scheduler_pkg;

  typedef enum logic [1:0] {
    LANE_LEFT  = 2'd0,
    LANE_MID   = 2'd1,
    LANE_RIGHT = 2'd2
  } lane_t;

  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned OBST_H       = 80;
  localparam int unsigned Y_LIMIT_DEF  = SCREEN_H + OBST_H;
  localparam int unsigned LANE_CX_LEFT  = SCREEN_W / 6;
  localparam int unsigned LANE_CX_MID   = SCREEN_W / 2;
  localparam int unsigned LANE_CX_RIGHT = (SCREEN_W * 5) / 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_RETIRE,
    ST_SPAWN
  } state_t;

  function automatic lane_t lane_first(input logic [7:0] r);
    return (r[1:0] == 2'd3) ? LANE_LEFT : lane_t'(r[1:0]);
  endfunction

  // Offset of 1 or 2 modulo 3 can never land on l0, so one lane always stays open.
  function automatic lane_t lane_second(input lane_t l0, input logic r2);
    logic [2:0] s;
    s = 3'(l0) + 3'd1 + 3'(r2);
    if (s >= 3'd3) s = s - 3'd3;
    return lane_t'(s[1:0]);
  endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Control inputs and per-slot obstacle outputs between game FSM, scheduler and draw logic.
interface obstacle_scheduler_if #(parameter int unsigned NUM_SLOTS = 4);
  logic                     tick;
  logic                     run;
  logic                     clear;
  logic [7:0]               rnd;
  logic [NUM_SLOTS*10-1:0]  slot_y;
  logic [NUM_SLOTS*2-1:0]   slot_lane;
  logic [NUM_SLOTS-1:0]     slot_active;
  logic [15:0]              score;
  logic [3:0]               step;
  logic                     frame_done;

  modport master (
    output tick, run, clear, rnd,
    input  slot_y, slot_lane, slot_active, score, step, frame_done
  );

  modport slave (
    input  tick, run, clear, rnd,
    output slot_y, slot_lane, slot_active, score, step, frame_done
  );
endinterface

// File: rtl/obstacle_scheduler_free_slot_finder.sv
// Priority encoder returning the lowest and next-lowest inactive slot indices.
module obstacle_scheduler_free_slot_finder #(
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0] slot_active,
  output logic [2:0]           first_idx,
  output logic                 first_valid,
  output logic [2:0]           second_idx,
  output logic                 second_valid
);

  always_comb begin
    first_idx    = '0;
    first_valid  = 1'b0;
    second_idx   = '0;
    second_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_active[i]) begin
        if (!first_valid) begin
          first_valid = 1'b1;
          first_idx   = 3'(i);
        end else if (!second_valid) begin
          second_valid = 1'b1;
          second_idx   = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle slot scheduler: per-tick move, retire/score, and spaced spawning of obstacle rows.
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned STEP_INIT  = 4,
  parameter int unsigned STEP_MAX   = 8,
  parameter int unsigned SPAWN_GAP  = 160,
  parameter int unsigned Y_LIMIT    = 560,
  parameter int unsigned RAMP_SHIFT = 4
) (
  input logic                 clk,
  input logic                 reset,
  obstacle_scheduler_if.slave io
);

  state_t           state, state_nx;
  logic [9:0]       y_q    [NUM_SLOTS];
  logic [1:0]       lane_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] active_q;
  logic [15:0]      score_q;
  logic [3:0]       step_q;
  logic [9:0]       gap_q;
  logic             frame_q;

  logic [2:0] first_idx, second_idx;
  logic       first_valid, second_valid;

  obstacle_scheduler_free_slot_finder #(.NUM_SLOTS(NUM_SLOTS)) u_finder (
    .slot_active  (active_q),
    .first_idx    (first_idx),
    .first_valid  (first_valid),
    .second_idx   (second_idx),
    .second_valid (second_valid)
  );

  always_ff @(posedge clk) begin
    if (reset || io.clear) state <= ST_IDLE;
    else                   state <= state_nx;
  end

  // Once past IDLE the sequence always completes; run only gates the start.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (io.tick && io.run) state_nx = ST_MOVE;
      ST_MOVE:   state_nx = ST_RETIRE;
      ST_RETIRE: state_nx = ST_SPAWN;
      ST_SPAWN:  state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  logic [NUM_SLOTS-1:0] retire_mask;
  logic [3:0]           retire_cnt;
  logic [16:0]          score_sum;
  logic [15:0]          score_new;
  logic                 ramp;
  logic [10:0]          gap_sum;
  logic [9:0]           gap_move;
  logic                 do_spawn, do_second;
  lane_t                lane0, lane1;

  always_comb begin
    retire_cnt = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      retire_mask[i] = active_q[i] && (y_q[i] >= 10'(Y_LIMIT));
      retire_cnt     = retire_cnt + 4'(retire_mask[i]);
    end
    score_sum = {1'b0, score_q} + 17'(retire_cnt);
    score_new = score_sum[16] ? '1 : score_sum[15:0];
    ramp      = (score_new >> RAMP_SHIFT) != (score_q >> RAMP_SHIFT);
    gap_sum   = {1'b0, gap_q} + 11'(step_q);
    gap_move  = gap_sum[10] ? '1 : gap_sum[9:0];
    do_spawn  = (gap_q >= 10'(SPAWN_GAP)) && first_valid;
    do_second = do_spawn && io.rnd[7] && second_valid;
    lane0     = lane_first(io.rnd);
    lane1     = lane_second(lane0, io.rnd[2]);
  end

  always_ff @(posedge clk) begin
    if (reset || io.clear) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        y_q[i]    <= '0;
        lane_q[i] <= '0;
      end
      active_q <= '0;
      score_q  <= '0;
      step_q   <= 4'(STEP_INIT);
      gap_q    <= 10'(SPAWN_GAP);
      frame_q  <= 1'b0;
    end else begin
      frame_q <= (state == ST_RETIRE);
      case (state)
        ST_MOVE: begin
          for (int unsigned i = 0; i < NUM_SLOTS; i++)
            if (active_q[i]) y_q[i] <= y_q[i] + 10'(step_q);
          gap_q <= gap_move;
        end
        ST_RETIRE: begin
          for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (retire_mask[i]) begin
              active_q[i] <= 1'b0;
              y_q[i]      <= '0;
            end
          end
          score_q <= score_new;
          if (ramp && (step_q < 4'(STEP_MAX))) step_q <= step_q + 4'd1;
        end
        ST_SPAWN: begin
          for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (do_spawn && (first_idx == 3'(i))) begin
              active_q[i] <= 1'b1;
              y_q[i]      <= '0;
              lane_q[i]   <= lane0;
            end
            if (do_second && (second_idx == 3'(i))) begin
              active_q[i] <= 1'b1;
              y_q[i]      <= '0;
              lane_q[i]   <= lane1;
            end
          end
          if (do_spawn) gap_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      io.slot_y[10*i +: 10]  = y_q[i];
      io.slot_lane[2*i +: 2] = lane_q[i];
    end
  end

  assign io.slot_active = active_q;
  assign io.score       = score_q;
  assign io.step        = step_q;
  assign io.frame_done  = frame_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: per-tick expectations queued, checked after each frame_done.
module tb_obstacle_scheduler;
  localparam int unsigned NS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  obstacle_scheduler_if #(.NUM_SLOTS(NS)) bus();

  obstacle_scheduler #(
    .NUM_SLOTS(NS), .STEP_INIT(4), .STEP_MAX(8), .SPAWN_GAP(160), .Y_LIMIT(560), .RAMP_SHIFT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  typedef struct packed {
    logic [NS*10-1:0] y;
    logic [NS*2-1:0]  lane;
    logic [NS-1:0]    act;
    logic [15:0]      score;
    logic [3:0]       step;
  } snap_t;

  snap_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  int my[NS];
  int ml[NS];
  bit ma[NS];
  int mscore, mstep, mgap;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      my[i] = 0; ml[i] = 0; ma[i] = 1'b0;
    end
    mscore = 0; mstep = 4; mgap = 160;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s = '0;
    for (int i = 0; i < NS; i++) begin
      s.y[i*10 +: 10]  = 10'(my[i]);
      s.lane[i*2 +: 2] = 2'(ml[i]);
      s.act[i]         = ma[i];
    end
    s.score = 16'(mscore);
    s.step  = 4'(mstep);
    return s;
  endfunction

  task automatic model_tick(input logic [7:0] r);
    int n, old, f0, f1, l0;
    for (int i = 0; i < NS; i++) if (ma[i]) my[i] += mstep;
    mgap += mstep;
    if (mgap > 1023) mgap = 1023;
    n = 0;
    for (int i = 0; i < NS; i++) begin
      if (ma[i] && my[i] >= 560) begin
        ma[i] = 1'b0; my[i] = 0; n++;
      end
    end
    old = mscore;
    mscore += n;
    if (mscore > 65535) mscore = 65535;
    if ((mscore / 16) != (old / 16) && mstep < 8) mstep++;
    if (mgap >= 160) begin
      f0 = -1; f1 = -1;
      for (int i = 0; i < NS; i++) begin
        if (!ma[i]) begin
          if (f0 < 0) f0 = i;
          else if (f1 < 0) f1 = i;
        end
      end
      if (f0 >= 0) begin
        l0 = int'(r) % 4;
        if (l0 == 3) l0 = 0;
        ma[f0] = 1'b1; my[f0] = 0; ml[f0] = l0;
        mgap = 0;
        if (int'(r) >= 128 && f1 >= 0) begin
          ma[f1] = 1'b1; my[f1] = 0; ml[f1] = (l0 + 1 + (int'(r) / 4) % 2) % 3;
        end
      end
    end
  endtask

  // Call at a negedge; returns at the negedge where spawn results are visible.
  task automatic do_tick(input logic [7:0] r, input int probe_y0);
    int lat;
    model_tick(r);
    exp_q.push_back(model_snap());
    bus.rnd  = r;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    lat = 1;
    while (bus.frame_done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 2 && probe_y0 >= 0) check("y_at_T2", bus.slot_y[9:0], 64'(probe_y0));
    end
    check("frame_latency", 64'(lat), 64'd3);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    snap_t e, got;
    forever begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        @(negedge clk);
        got = '{y: bus.slot_y, lane: bus.slot_lane, act: bus.slot_active, score: bus.score, step: bus.step};
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_frame: got frame_done with no tick issued, required none");
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            mismatched++;
            $display("FAIL frame: got y=%h lane=%h act=%b score=%0d step=%0d, required y=%h lane=%h act=%b score=%0d step=%0d",
                     got.y, got.lane, got.act, got.score, got.step, e.y, e.lane, e.act, e.score, e.step);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] r;
    logic [15:0] prev_score;
    bit saw_double, saw16;
    int max_step, fd;
    snap_t e;

    bus.tick = 1'b0; bus.run = 1'b1; bus.clear = 1'b0; bus.rnd = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_active", bus.slot_active, 64'h0);
    check("rst_y", bus.slot_y, 64'h0);
    check("rst_lane", bus.slot_lane, 64'h0);
    check("rst_score", bus.score, 64'h0);
    check("rst_step", bus.step, 64'd4);
    check("rst_frame_done", bus.frame_done, 64'h0);

    // First tick spawns immediately: slot0, lane 1.
    do_tick(8'h01, 0);
    check("t1_active", bus.slot_active, 64'b0001);
    check("t1_lane", bus.slot_lane[1:0], 64'd1);
    check("t1_score", bus.score, 64'd0);

    // Code 3 maps to lane 0; double row with rnd[2]=0 puts slot1 in lane 1.
    pulse_clear();
    do_tick(8'h83, -1);
    check("dbl_active", bus.slot_active, 64'b0011);
    check("dbl_lanes", bus.slot_lane[3:0], 64'b0100);

    for (int k = 0; k < 256; k++) begin
      r = 8'(k);
      pulse_clear();
      do_tick(r, -1);
      if (r[7]) check("dbl_lanes_differ", 64'(bus.slot_lane[1:0] != bus.slot_lane[3:2]), 64'd1);
      else      check("single_row", bus.slot_active, 64'b0001);
    end

    // Spacing: second row only when last_gap has climbed back to 160 (40 moves of 4).
    pulse_clear();
    do_tick(8'h00, -1);
    for (int k = 2; k <= 40; k++) do_tick(8'h00, -1);
    check("no_early_spawn", bus.slot_active, 64'b0001);
    do_tick(8'h00, 160);
    check("gap_spawn", bus.slot_active, 64'b0011);
    check("gap_spawn_y0", bus.slot_y[9:0], 64'd160);

    // Long run: retirements, double retirements and step ramp up to the cap.
    saw_double = 1'b0; saw16 = 1'b0; max_step = 0;
    for (int k = 0; k < 2500; k++) begin
      prev_score = bus.score;
      do_tick(8'h80 | 8'(k * 13), -1);
      if (bus.score - prev_score == 16'd2) saw_double = 1'b1;
      if (!saw16 && bus.score >= 16'd16) begin
        saw16 = 1'b1;
        check("ramp_step5", bus.step, 64'd5);
      end
      if (int'(bus.step) > max_step) max_step = int'(bus.step);
    end
    check("saw_double_retire", 64'(saw_double), 64'd1);
    check("step_capped", 64'(max_step), 64'd8);
    check("step_final", bus.step, 64'd8);

    // run low: ticks ignored, everything holds.
    bus.run = 1'b0;
    repeat (10) begin
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      @(negedge clk);
    end
    e = model_snap();
    check("frz_y", bus.slot_y, 64'(e.y));
    check("frz_lane", bus.slot_lane, 64'(e.lane));
    check("frz_active", bus.slot_active, 64'(e.act));
    check("frz_score", bus.score, 64'(e.score));
    check("frz_step", bus.step, 64'(e.step));
    bus.run = 1'b1;

    // clear while in MOVE aborts the sequence without a frame_done.
    bus.rnd  = 8'h00;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick  = 1'b0;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    model_reset();
    check("clr_active", bus.slot_active, 64'h0);
    check("clr_y", bus.slot_y, 64'h0);
    check("clr_score", bus.score, 64'h0);
    check("clr_step", bus.step, 64'd4);
    fd = 0;
    repeat (5) begin
      if (bus.frame_done === 1'b1) fd++;
      @(negedge clk);
    end
    check("clr_no_frame", 64'(fd), 64'd0);

    do_tick(8'h02, -1);
    check("post_clr_lane", bus.slot_lane[1:0], 64'd2);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
